async_fifo_write_arbiter: RTL

Shares the single write port of the async FIFO among NUM_REQ requesters in the write clock domain. Bursts are framed by a last flag. Arbitration is round-robin, and once a requester is granted it keeps the port until its burst completes, so each burst lands contiguously in the FIFO. The block sits directly in front of the FIFO write control. It drives fifo_push and write data, and it throttles every requester on fifo_full so no push is ever issued while the FIFO is full.

---
 rtl/async_fifo_write_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/async_fifo_write_arbiter.sv
// Round-robin write-port arbiter in front of async FIFO write control.
// Grants are held for a whole burst so each burst lands contiguously.
module async_fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [NUM_REQ-1:0]            grant_onehot,
  output logic                          busy,
  output logic                          burst_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   pick_vld;
  logic [IW-1:0]          pick_idx;
  logic [IW-1:0]          owner_nxt;
  logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int idx;
    logic [IW-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign owner_nxt = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    req_ready  = '0;
    fifo_push  = 1'b0;
    fifo_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BURST;
          owner_d = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
        end
      end
      BURST: begin
        fifo_wdata         = data_arr[owner_q];
        req_ready[owner_q] = !fifo_full;
        fifo_push          = req_valid[owner_q] & !fifo_full;
        if (fifo_push) begin
          if (req_last[owner_q]) begin
            state_d  = IDLE;
            rr_ptr_d = owner_nxt;
            grant_d  = '0;
            cnt_d    = '0;
          end else if (cnt_q == CNT_MAX) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Nothing reaches the FIFO while reset is asserted
    if (reset) begin
      req_ready  = '0;
      fifo_push  = 1'b0;
      fifo_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign grant_onehot = grant_q;
  assign busy         = (state_q == BURST);
  assign burst_err    = err_q;

endmodule
